vga_frame_monitor: RTL and testbench
====================================

// Module: vga_frame_monitor
// PURPOSE
//  Receive-side checker for the VGA output of the display pipeline: sits on VGA_CLK/HS/VS/BLANK_n/RGB
//  in the same clock domain, measures line/frame geometry and sync widths, and computes a per-frame
//  CRC of active pixels. Results are exposed as Avalon-MM read registers for HPS self-test and regression.
// PARAMETERS
//  H_ACTIVE   640  expected active pixels per line
//  V_ACTIVE   480  expected active lines per frame
//  HSYNC_PX   96   expected HS low width, in pixel strobes
//  VSYNC_LN   2    expected VS low width, in HS falling edges
//  TIMEOUT_PX 1024 pixel strobes without an HS falling edge before loss-of-sync
// PORTS
//  clk          in   1   system clock (50 MHz)
//  reset        in   1   asynchronous, active-high reset
//  chipselect   in   1   Avalon slave select
//  write        in   1   Avalon write strobe
//  address      in   3   register index
//  writedata    in   32  write data
//  readdata     out  32  read data, registered
//  VGA_CLK      in   1   pixel clock (level, sampled in clk domain)
//  VGA_HS       in   1   horizontal sync, active low
//  VGA_VS       in   1   vertical sync, active low
//  VGA_BLANK_n  in   1   high = active video
//  VGA_R/G/B    in   8   colour channels; only [7:3] are used
// BEHAVIOUR
//  - One clock, clk; reset is asynchronous and active-high. Reset: readdata=0, all counters/flags=0, CRC=16'hFFFF, state IDLE.
//  - Pixel strobe ps = VGA_CLK & ~vga_clk_q (vga_clk_q = VGA_CLK registered). All video inputs sampled only on ps;
//    HS/VS edges = compare against values held from previous ps.
//  - Active pixel: ps & BLANK_n. line_px increments (10-bit, saturating at 1023); CRC-16-CCITT (poly 0x1021, MSB first)
//    absorbs 15 bits {R[7:3],G[7:3],B[7:3]}, R[7] first, all 15 bits in one clk.
//  - HS falling: if line_px!=0 {lines+=1; if line_px!=H_ACTIVE set WIDTH_ERR; last_width<=line_px}; line_px<=0;
//    hs_cnt<=0; to_cnt<=0; if VS low, vs_lines+=1.
//  - HS low: hs_cnt+=1 per ps. HS rising: if hs_cnt!=HSYNC_PX set HSYNC_ERR.
//  - VS falling: last_height<=lines, last_crc<=CRC, frame_count+=1 (32-bit, wraps); if lines!=V_ACTIVE set HEIGHT_ERR;
//    then lines<=0, CRC<=16'hFFFF, vs_lines<=0. VS rising: if vs_lines!=VSYNC_LN set VSYNC_ERR.
//  - FSM: IDLE -> SYNCED on first VS falling (only counter reset/CRC init done on it; no checks, no frame_count, no latch).
//    In IDLE all error checks suppressed. SYNCED -> IDLE when to_cnt reaches TIMEOUT_PX; sets TIMEOUT_ERR.
//  - Each error-set event also increments err_count (16-bit, saturates at 16'hFFFF); multiple in one clk count once.
//  - Registers (read: chipselect & ~write, readdata valid next clk; unmapped address reads 0):
//    0 STATUS [0]=SYNCED [1]WIDTH_ERR [2]HEIGHT_ERR [3]HSYNC_ERR [4]VSYNC_ERR [5]TIMEOUT_ERR (sticky)
//    1 GEOM   [9:0]=last_width [25:16]=last_height
//    2 CRC    [15:0]=last_crc
//    3 FRAMES [31:0]=frame_count
//    4 ERRCNT [15:0]=err_count
//  - Write addr 0 with writedata[0]=1: clear sticky errors and err_count. Clear and new error in same clk: error wins,
//    err_count<=1. Writes to other addresses ignored.
//  - Reset mid-frame: immediate return to IDLE; next full frame after the following VS falling is the first checked.
// TESTING
//  1 Drive from vga_counters, BLANK-gated constant RGB=8'hF8 each, 2 frames -> STATUS=0x01, GEOM=0x01E0_0280, FRAMES=1, ERRCNT=0.
//  2 Same, RGB=0 vs RGB=8'hF8 -> CRC differs; CRC equals bench reference model (0x1021, init 0xFFFF, 15b/pixel).
//  3 Force BLANK_n low for one pixel on line 100 -> WIDTH_ERR=1, ERRCNT=1, GEOM width reflects last line (640).
//  4 Stretch HS low by 2 clk (1 extra strobe) once -> HSYNC_ERR=1; write 0x1 to addr 0 -> STATUS=0x01, ERRCNT=0.
//  5 Hold HS high for 1100 strobes -> TIMEOUT_ERR=1, SYNCED=0; resume -> SYNCED=1 after next VS falling, no spurious errors.
//  6 Assert reset mid-frame 200 -> all regs 0; next checked frame reports FRAMES=1, no errors.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// ============================================================================
// Module  : vga_frame_monitor
// Purpose : Receive-side VGA checker: line/frame geometry, sync widths, loss of
//           sync and per-frame CRC-16 of active pixels, readable over Avalon-MM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_frame_monitor #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int HSYNC_PX   = 96,
    parameter int VSYNC_LN   = 2,
    parameter int TIMEOUT_PX = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_n,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_SYNCED = 1'b1;
    localparam int         TO_W     = $clog2(TIMEOUT_PX + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_PX);
    localparam logic [9:0] SAT10    = 10'h3FF;

    logic [0:0]      state_q, state_d;
    logic            vga_clk_q, hs_q, vs_q;
    logic [9:0]      line_px_q, line_px_d, lines_q, lines_d;
    logic [9:0]      hs_cnt_q, hs_cnt_d, vs_lines_q, vs_lines_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]     crc_q, crc_d, last_crc_q, last_crc_d;
    logic [9:0]      last_width_q, last_width_d, last_height_q, last_height_d;
    logic [31:0]     frame_count_q, frame_count_d;
    logic [4:0]      err_q, err_d, new_err;
    logic [15:0]     err_count_q, err_count_d;
    logic [31:0]     readdata_q, readdata_d;

    logic ps, act, hs_fall, hs_rise, vs_fall, vs_rise, clr;
    logic synced, sync_acq, timeout_ev;
    logic [14:0] pix;
    logic unused_ok;

    assign ps      = VGA_CLK & ~vga_clk_q;
    assign act     = ps & VGA_BLANK_n;
    assign hs_fall = ps & hs_q & ~VGA_HS;
    assign hs_rise = ps & ~hs_q & VGA_HS;
    assign vs_fall = ps & vs_q & ~VGA_VS;
    assign vs_rise = ps & ~vs_q & VGA_VS;
    assign pix     = {VGA_R[7:3], VGA_G[7:3], VGA_B[7:3]};
    assign clr     = chipselect & write & (address == 3'd0) & writedata[0];
    assign unused_ok = ^{writedata[31:1], VGA_R[2:0], VGA_G[2:0], VGA_B[2:0]};
    assign readdata  = readdata_q;

    // CRC-16-CCITT over 15 bits, MSB first, unrolled into one clock
    function automatic logic [15:0] crc15_step(input logic [15:0] crc, input logic [14:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 14; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (vs_fall) state_d = S_SYNCED;
            S_SYNCED: if (to_cnt_q == TO_MAX) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        synced     = 1'b0;
        sync_acq   = 1'b0;
        timeout_ev = 1'b0;
        case (state_q)
            S_IDLE:   sync_acq = vs_fall;
            S_SYNCED: begin
                synced     = 1'b1;
                timeout_ev = (to_cnt_q == TO_MAX);
            end
            default:  ;
        endcase
    end

    always_comb begin
        line_px_d     = line_px_q;
        lines_d       = lines_q;
        hs_cnt_d      = hs_cnt_q;
        vs_lines_d    = vs_lines_q;
        to_cnt_d      = to_cnt_q;
        crc_d         = crc_q;
        last_width_d  = last_width_q;
        last_height_d = last_height_q;
        last_crc_d    = last_crc_q;
        frame_count_d = frame_count_q;
        new_err       = 5'b0;

        if (act) begin
            if (line_px_q != SAT10) line_px_d = line_px_q + 10'd1;
            crc_d = crc15_step(crc_q, pix);
        end
        if (ps && to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
        if (ps && !VGA_HS && hs_cnt_q != SAT10) hs_cnt_d = hs_cnt_q + 10'd1;

        if (hs_fall) begin
            if (line_px_q != 10'd0) begin
                if (lines_q != SAT10) lines_d = lines_q + 10'd1;
                new_err[0]   = synced && (line_px_q != 10'(H_ACTIVE));
                last_width_d = line_px_q;
            end
            line_px_d = 10'd0;
            // The falling strobe itself is the first low strobe of the pulse
            hs_cnt_d  = 10'd1;
            to_cnt_d  = '0;
        end
        if (hs_rise) new_err[2] = synced && (hs_cnt_q != 10'(HSYNC_PX));

        if (vs_fall) begin
            if (synced) begin
                last_height_d = lines_d;
                last_crc_d    = crc_d;
                frame_count_d = frame_count_q + 32'd1;
                new_err[1]    = (lines_d != 10'(V_ACTIVE));
            end
            lines_d    = 10'd0;
            crc_d      = 16'hFFFF;
            vs_lines_d = 10'd0;
        end
        if (hs_fall && !VGA_VS && vs_lines_d != SAT10) vs_lines_d = vs_lines_d + 10'd1;
        if (vs_rise) new_err[3] = synced && (vs_lines_q != 10'(VSYNC_LN));

        new_err[4] = timeout_ev;
        if (sync_acq) to_cnt_d = '0;
    end

    // A new error in the same clock as a clear survives and counts as one
    always_comb begin
        err_d       = (clr ? 5'b0 : err_q) | new_err;
        err_count_d = err_count_q;
        if (clr) begin
            err_count_d = (|new_err) ? 16'd1 : 16'd0;
        end else if ((|new_err) && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (chipselect && !write) begin
            case (address)
                3'd0:    readdata_d = {26'd0, err_q, synced};
                3'd1:    readdata_d = {6'd0, last_height_q, 6'd0, last_width_q};
                3'd2:    readdata_d = {16'd0, last_crc_q};
                3'd3:    readdata_d = frame_count_q;
                3'd4:    readdata_d = {16'd0, err_count_q};
                default: readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_clk_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_px_q     <= 10'd0;
            lines_q       <= 10'd0;
            hs_cnt_q      <= 10'd0;
            vs_lines_q    <= 10'd0;
            to_cnt_q      <= '0;
            crc_q         <= 16'hFFFF;
            last_crc_q    <= 16'd0;
            last_width_q  <= 10'd0;
            last_height_q <= 10'd0;
            frame_count_q <= 32'd0;
            err_q         <= 5'd0;
            err_count_q   <= 16'd0;
            readdata_q    <= 32'd0;
        end else begin
            vga_clk_q     <= VGA_CLK;
            if (ps) begin
                hs_q <= VGA_HS;
                vs_q <= VGA_VS;
            end
            line_px_q     <= line_px_d;
            lines_q       <= lines_d;
            hs_cnt_q      <= hs_cnt_d;
            vs_lines_q    <= vs_lines_d;
            to_cnt_q      <= to_cnt_d;
            crc_q         <= crc_d;
            last_crc_q    <= last_crc_d;
            last_width_q  <= last_width_d;
            last_height_q <= last_height_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
            readdata_q    <= readdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
// ============================================================================
// Module  : tb_vga_frame_monitor
// Purpose : Self-checking bench driving scaled-down VGA timing with faults.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_frame_monitor;

    localparam int H_ACT = 16, V_ACT = 8, HS_PX = 4, VS_LN = 2, TO_PX = 64;
    localparam int H_TOT = 28, HS_START = 20, V_TOT = 14, VS_START = 10;
    localparam logic [31:0] GEOM_OK = (V_ACT << 16) | H_ACT;

    logic        clk = 1'b0;
    logic        reset, chipselect, write;
    logic [2:0]  address;
    logic [31:0] writedata, readdata;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int checks = 0, failures = 0;

    // Fault / stimulus knobs, applied only in frame f_frame
    int rgb_mode, f_frame, f_blank_line, f_blank_px, f_hs_mask, f_clear_line, f_hold_line;
    int m_crc, m_frame_crc;

    vga_frame_monitor #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .HSYNC_PX(HS_PX),
        .VSYNC_LN(VS_LN), .TIMEOUT_PX(TO_PX)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference CRC: bit-serial polynomial division, 15 data bits MSB first
    function automatic int crc_model(input int crc, input int d);
        int c, top;
        c = crc;
        for (int i = 14; i >= 0; i--) begin
            top = ((c >> 15) ^ (d >> i)) & 1;
            c   = ((c << 1) & 'hFFFF) ^ (top ? 'h1021 : 0);
        end
        return c;
    endfunction

    task automatic clear_knobs();
        rgb_mode = 0; f_frame = -1; f_blank_line = -1; f_blank_px = -1;
        f_hs_mask = 0; f_clear_line = -1; f_hold_line = -1;
    endtask

    task automatic apply_reset();
        clear_knobs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b0; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic run_lines(input int fidx, input int l0, input int l1);
        bit flt, blank, hs_low, vs_low, stretch, clr;
        logic [7:0] r, g, b;
        for (int line = l0; line <= l1; line++) begin
            for (int h = 0; h < H_TOT; h++) begin
                flt     = (fidx == f_frame);
                stretch = flt && (((f_hs_mask >> line) & 1) == 1);
                blank   = (line < V_ACT) && (h < H_ACT) &&
                          !(flt && line == f_blank_line && h == f_blank_px);
                hs_low  = (h >= HS_START) && (h < HS_START + HS_PX + (stretch ? 1 : 0));
                if (flt && f_hold_line >= 0 && line >= f_hold_line && line < f_hold_line + 3)
                    hs_low = 1'b0;
                vs_low  = (line >= VS_START) && (line < VS_START + VS_LN);
                clr     = flt && line == f_clear_line && h == HS_START + HS_PX + (stretch ? 1 : 0);
                case (rgb_mode)
                    0: begin r = 8'hF8; g = 8'hF8; b = 8'hF8; end
                    1: begin r = 8'h00; g = 8'h00; b = 8'h00; end
                    default: begin
                        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                    end
                endcase
                if (!blank) begin r = 8'h00; g = 8'h00; b = 8'h00; end
                if (line == 0 && h == 0) m_crc = 'hFFFF;
                if (line == VS_START && h == 0) m_frame_crc = m_crc;
                if (blank) m_crc = crc_model(m_crc, ((r >> 3) << 10) | ((g >> 3) << 5) | (b >> 3));
                @(negedge clk);
                VGA_CLK = 1'b1; VGA_HS = ~hs_low; VGA_VS = ~vs_low; VGA_BLANK_n = blank;
                VGA_R = r; VGA_G = g; VGA_B = b;
                if (clr) begin
                    chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'd1;
                end
                @(negedge clk);
                VGA_CLK = 1'b0; chipselect = 1'b0; write = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input int fidx);
        run_lines(fidx, 0, V_TOT - 1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        checks++;
        if (readdata !== 32'd0) begin
            failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'd0);
        end
        for (int a = 0; a < 6; a++) begin
            read_reg(3'(a), d);
            checks++;
            if (d !== 32'd0) begin
                failures++; $display("FAIL reset_reg%0d got=%h exp=%h", a, d, 32'd0);
            end
        end
    endtask

    task automatic test_constant_frames(output int crc_f8);
        logic [31:0] d;
        apply_reset();
        run_frame(0);
        run_frame(1);
        crc_f8 = m_frame_crc;
        read_reg(0, d); checks++;
        if (d !== 32'h01) begin failures++; $display("FAIL const_status got=%h exp=%h", d, 32'h01); end
        read_reg(1, d); checks++;
        if (d !== GEOM_OK) begin failures++; $display("FAIL const_geom got=%h exp=%h", d, GEOM_OK); end
        read_reg(2, d); checks++;
        if (d !== 32'(m_frame_crc)) begin failures++; $display("FAIL const_crc got=%h exp=%h", d, m_frame_crc); end
        read_reg(3, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL const_frames got=%h exp=%h", d, 32'd1); end
        read_reg(4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL const_errcnt got=%h exp=%h", d, 32'd0); end
        read_reg(7, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_crc_patterns(input int crc_f8);
        logic [31:0] d;
        apply_reset();
        rgb_mode = 1;
        run_frame(0);
        run_frame(1);
        read_reg(2, d); checks++;
        if (d !== 32'(m_frame_crc)) begin failures++; $display("FAIL zero_crc got=%h exp=%h", d, m_frame_crc); end
        checks++;
        if (d === 32'(crc_f8)) begin failures++; $display("FAIL zero_crc_distinct got=%h exp=not %h", d, crc_f8); end
        apply_reset();
        rgb_mode = 2;
        for (int f = 0; f < 3; f++) run_frame(f);
        read_reg(2, d); checks++;
        if (d !== 32'(m_frame_crc)) begin failures++; $display("FAIL rand_crc got=%h exp=%h", d, m_frame_crc); end
        read_reg(3, d); checks++;
        if (d !== 32'd2) begin failures++; $display("FAIL rand_frames got=%h exp=%h", d, 32'd2); end
        read_reg(0, d); checks++;
        if (d !== 32'h01) begin failures++; $display("FAIL rand_status got=%h exp=%h", d, 32'h01); end
    endtask

    task automatic test_width_err();
        logic [31:0] d;
        apply_reset();
        f_frame = 1;
        f_blank_line = $urandom_range(0, V_ACT - 2);
        f_blank_px = $urandom_range(0, H_ACT - 1);
        run_frame(0);
        run_frame(1);
        read_reg(0, d); checks++;
        if (d !== 32'h03) begin failures++; $display("FAIL width_status got=%h exp=%h", d, 32'h03); end
        read_reg(4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL width_errcnt got=%h exp=%h", d, 32'd1); end
        read_reg(1, d); checks++;
        if (d !== GEOM_OK) begin failures++; $display("FAIL width_geom got=%h exp=%h", d, GEOM_OK); end
        read_reg(2, d); checks++;
        if (d !== 32'(m_frame_crc)) begin failures++; $display("FAIL width_crc got=%h exp=%h", d, m_frame_crc); end
    endtask

    task automatic test_hsync_clear();
        logic [31:0] d;
        apply_reset();
        f_frame = 1;
        f_hs_mask = 1 << $urandom_range(0, V_TOT - 1);
        run_frame(0);
        run_frame(1);
        read_reg(0, d); checks++;
        if (d !== 32'h09) begin failures++; $display("FAIL hsync_status got=%h exp=%h", d, 32'h09); end
        read_reg(4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL hsync_errcnt got=%h exp=%h", d, 32'd1); end
        write_reg(0, 32'h2);
        write_reg(1, 32'h1);
        read_reg(0, d); checks++;
        if (d !== 32'h09) begin failures++; $display("FAIL noclear_status got=%h exp=%h", d, 32'h09); end
        write_reg(0, 32'h1);
        read_reg(0, d); checks++;
        if (d !== 32'h01) begin failures++; $display("FAIL clear_status got=%h exp=%h", d, 32'h01); end
        read_reg(4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL clear_errcnt got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_clear_collision();
        logic [31:0] d;
        apply_reset();
        f_frame = 1;
        f_hs_mask = (1 << 2) | (1 << 3);
        f_clear_line = 3;
        run_frame(0);
        run_frame(1);
        read_reg(0, d); checks++;
        if (d !== 32'h09) begin failures++; $display("FAIL collide_status got=%h exp=%h", d, 32'h09); end
        read_reg(4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL collide_errcnt got=%h exp=%h", d, 32'd1); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        apply_reset();
        f_frame = 1;
        f_hold_line = 3;
        run_frame(0);
        run_lines(1, 0, VS_START - 1);
        read_reg(0, d); checks++;
        if (d !== 32'h20) begin failures++; $display("FAIL timeout_status got=%h exp=%h", d, 32'h20); end
        read_reg(4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL timeout_errcnt got=%h exp=%h", d, 32'd1); end
        run_lines(1, VS_START, V_TOT - 1);
        read_reg(0, d); checks++;
        if (d !== 32'h21) begin failures++; $display("FAIL resync_status got=%h exp=%h", d, 32'h21); end
        read_reg(3, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL resync_frames got=%h exp=%h", d, 32'd0); end
        run_frame(2);
        read_reg(0, d); checks++;
        if (d !== 32'h21) begin failures++; $display("FAIL after_status got=%h exp=%h", d, 32'h21); end
        read_reg(3, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL after_frames got=%h exp=%h", d, 32'd1); end
        read_reg(4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL after_errcnt got=%h exp=%h", d, 32'd1); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int rl;
        apply_reset();
        rgb_mode = 2;
        rl = $urandom_range(1, V_ACT - 2);
        run_frame(0);
        run_frame(1);
        run_lines(2, 0, rl - 1);
        read_reg(3, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL pre_reset_frames got=%h exp=%h", d, 32'd1); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++;
        if (readdata !== 32'd0) begin failures++; $display("FAIL mid_reset_readdata got=%h exp=%h", readdata, 32'd0); end
        for (int a = 0; a < 5; a++) begin
            read_reg(3'(a), d); checks++;
            if (d !== 32'd0) begin failures++; $display("FAIL mid_reset_reg%0d got=%h exp=%h", a, d, 32'd0); end
        end
        run_lines(2, rl, V_TOT - 1);
        run_frame(3);
        read_reg(3, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL post_reset_frames got=%h exp=%h", d, 32'd1); end
        read_reg(0, d); checks++;
        if (d !== 32'h01) begin failures++; $display("FAIL post_reset_status got=%h exp=%h", d, 32'h01); end
        read_reg(4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL post_reset_errcnt got=%h exp=%h", d, 32'd0); end
        read_reg(2, d); checks++;
        if (d !== 32'(m_frame_crc)) begin failures++; $display("FAIL post_reset_crc got=%h exp=%h", d, m_frame_crc); end
    endtask

    initial begin
        int crc_f8;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;
        VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
        VGA_R = 8'd0; VGA_G = 8'd0; VGA_B = 8'd0;
        m_crc = 'hFFFF; m_frame_crc = 'hFFFF;
        clear_knobs();
        test_reset();
        test_constant_frames(crc_f8);
        test_crc_patterns(crc_f8);
        test_width_err();
        test_hsync_clear();
        test_clear_collision();
        test_timeout();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
